// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding and default latencies.
// Imported by the MDU itself, the D-stage stall unit and the E-stage decoder.
package mdu_pkg;

    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;

    localparam int MDU_MULT_CYCLES_DFLT = 5;
    localparam int MDU_DIV_CYCLES_DFLT  = 10;

endpackage

// File: rtl/mdu.sv
// E-stage multiply/divide unit: fixed-latency MULT/DIV into private HI/LO, plus MTHI/MTLO.
// Results are computed at accept, held in temp registers and committed when the counter expires.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DFLT,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DFLT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        req,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   hi_t_q, hi_t_d, lo_t_q, lo_t_d;

    logic [63:0] a_sx, b_sx, prod_s, prod_u;
    logic        b_zero;
    logic [31:0] a_mag, b_mag, b_mag_safe, u_den;
    logic [31:0] sq_mag, sr_mag, sq, sr, uq, ur;

    assign a_sx   = {{32{A[31]}}, A};
    assign b_sx   = {{32{B[31]}}, B};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special case.
    assign b_zero     = (B == 32'd0);
    assign a_mag      = A[31] ? (32'd0 - A) : A;
    assign b_mag      = B[31] ? (32'd0 - B) : B;
    assign b_mag_safe = b_zero ? 32'd1 : b_mag;
    assign u_den      = b_zero ? 32'd1 : B;
    assign sq_mag     = a_mag / b_mag_safe;
    assign sr_mag     = a_mag % b_mag_safe;
    assign sq         = (A[31] ^ B[31]) ? (32'd0 - sq_mag) : sq_mag;
    assign sr         = A[31] ? (32'd0 - sr_mag) : sr_mag;
    assign uq         = A / u_den;
    assign ur         = A % u_den;

    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        hi_t_d = hi_t_q;
        lo_t_d = lo_t_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                hi_d = hi_t_q;
                lo_d = lo_t_q;
            end
        end else if (start && !req) begin
            case (op)
                MDU_MULT: begin
                    {hi_t_d, lo_t_d} = prod_s;
                    cnt_d = CW'(MULT_CYCLES);
                end
                MDU_MULTU: begin
                    {hi_t_d, lo_t_d} = prod_u;
                    cnt_d = CW'(MULT_CYCLES);
                end
                MDU_DIV: begin
                    // Divide by zero commits the current HI/LO, i.e. leaves them untouched.
                    {hi_t_d, lo_t_d} = b_zero ? {hi_q, lo_q} : {sr, sq};
                    cnt_d = CW'(DIV_CYCLES);
                end
                MDU_DIVU: begin
                    {hi_t_d, lo_t_d} = b_zero ? {hi_q, lo_q} : {ur, uq};
                    cnt_d = CW'(DIV_CYCLES);
                end
                MDU_MTHI: hi_d = A;
                MDU_MTLO: lo_d = A;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            hi_t_q <= '0;
            lo_t_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            hi_t_q <= hi_t_d;
            lo_t_q <= lo_t_d;
        end
    end

    assign busy = (cnt_q != '0);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus randomized commands against a 64-bit arithmetic model.
module tb_mdu;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset, start, req;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    always #5 clk = ~clk;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .req   (req),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural result {HI, LO} of an arithmetic op, from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_arith(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] hi, input logic [31:0] lo);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            MDU_MULT:  return 64'(sa * sb);
            MDU_MULTU: return 64'(ua * ub);
            MDU_DIV:   return (b == 32'd0) ? {hi, lo} : {32'(sa % sb), 32'(sa / sb)};
            MDU_DIVU:  return (b == 32'd0) ? {hi, lo} : {32'(ua % ub), 32'(ua / ub)};
            default:   return {hi, lo};
        endcase
    endfunction

    // Issue one command; inj >= 0 drives a stray command in that busy cycle, which must be ignored.
    task automatic run_cmd(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic r, input int inj);
        int          n;
        logic [63:0] res;
        n   = 0;
        res = ref_arith(o, a, b, m_hi, m_lo);
        if (!r && (o == MDU_MULT || o == MDU_MULTU)) n = MC;
        if (!r && (o == MDU_DIV || o == MDU_DIVU))   n = DC;
        start = 1'b1; op = o; A = a; B = b; req = r;
        tick();
        start = 1'b0; req = 1'b0;
        if (!r && o == MDU_MTHI) m_hi = a;
        if (!r && o == MDU_MTLO) m_lo = a;
        for (int i = 0; i < n; i++) begin
            check("busy_during", {31'd0, busy}, 32'd1);
            check("hi_during", HI, m_hi);
            check("lo_during", LO, m_lo);
            if (i == inj) begin
                start = 1'b1; op = 3'($urandom_range(0, 7)); A = $urandom; B = $urandom;
                req = 1'($urandom_range(0, 1));
            end
            tick();
            start = 1'b0; req = 1'b0;
        end
        if (n != 0) {m_hi, m_lo} = res;
        check("busy_after", {31'd0, busy}, 32'd0);
        check("hi_after", HI, m_hi);
        check("lo_after", LO, m_lo);
        $display("cmd op=%0d A=%h B=%h req=%0d -> HI=%h LO=%h", o, a, b, r, HI, LO);
    endtask

    function automatic logic [31:0] pick(input logic allow_zero);
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return m_lo;
            3: return allow_zero ? 32'd0 : 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; req = 1'b0; op = MDU_NONE; A = '0; B = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);

        run_cmd(MDU_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, -1);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFF1);
        run_cmd(MDU_DIVU, 32'd7, 32'd2, 1'b0, -1);
        check("divu_lo", LO, 32'd3);
        check("divu_hi", HI, 32'd1);
        run_cmd(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 2);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);
        run_cmd(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
        check("ovf_lo", LO, 32'h8000_0000);
        check("ovf_hi", HI, 32'd0);

        run_cmd(MDU_MTHI, 32'h11, 32'd0, 1'b0, -1);
        run_cmd(MDU_MTLO, 32'h22, 32'd0, 1'b0, -1);
        run_cmd(MDU_DIV, 32'd99, 32'd0, 1'b0, -1);
        check("dz_hi", HI, 32'h11);
        check("dz_lo", LO, 32'h22);

        // MULTU, stray MTLO while busy, then reset in busy cycle 3.
        start = 1'b1; op = MDU_MULTU; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
        tick();
        start = 1'b1; op = MDU_MTLO; A = 32'h5;
        check("rst_busy1", {31'd0, busy}, 32'd1);
        tick();
        start = 1'b0;
        check("rst_busy2", {31'd0, busy}, 32'd1);
        check("mtlo_ignored", LO, 32'h22);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_hi", HI, 32'd0);
        check("rst_mid_lo", LO, 32'd0);
        repeat (DC + 2) tick();
        check("no_commit_busy", {31'd0, busy}, 32'd0);
        check("no_commit_hi", HI, 32'd0);
        check("no_commit_lo", LO, 32'd0);

        run_cmd(MDU_MTHI, 32'hABCD, 32'd0, 1'b1, -1);
        check("req_blocks", HI, 32'd0);
        run_cmd(MDU_MTHI, 32'hABCD, 32'd0, 1'b0, -1);
        check("mthi_hi", HI, 32'hABCD);

        for (int t = 0; t < 60; t++) begin
            logic [2:0]  o;
            logic [31:0] a, b;
            o = 3'($urandom_range(0, 7));
            a = pick(1'b1);
            b = pick(1'b1);
            run_cmd(o, a, b, 1'($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 9)) : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
